// File: rtl/cpu_phase_sequencer.sv
// Instruction-phase sequencer: walks FETCH/DECODE/EXECUTE/WRITEBACK, handshakes the fetch,
// and emits a registered phase code plus a 2nd-cycle load strobe for the downstream trigger.
module cpu_phase_sequencer #(
    parameter int FETCH_TIMEOUT = 15,
    parameter int EXEC_CYCLES   = 2
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Halt,
    input  logic       Mem_ack,
    input  logic       Skip_wb,
    output logic [1:0] Phase_bus,
    output logic       Phase_load,
    output logic       Mem_req,
    output logic       Fault,
    output logic [7:0] Instr_count
);

    localparam int AGE_MAX = (FETCH_TIMEOUT > EXEC_CYCLES) ? FETCH_TIMEOUT : EXEC_CYCLES;
    localparam int AGE_W   = $clog2(AGE_MAX + 2);

    localparam logic [AGE_W-1:0] AGE_ONE  = AGE_W'(1);
    localparam logic [AGE_W-1:0] AGE_TWO  = AGE_W'(2);
    localparam logic [AGE_W-1:0] AGE_TMO  = AGE_W'(FETCH_TIMEOUT);
    localparam logic [AGE_W-1:0] AGE_EXEC = AGE_W'(EXEC_CYCLES);
    localparam logic [AGE_W-1:0] AGE_SAT  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALTED,
        S_FAULT
    } state_t;

    state_t           state_q, state_d;
    logic [AGE_W-1:0] age_q, age_d;
    logic             acked_q, acked_d;
    logic             skip_q, skip_d;
    logic             halt_pend_q, halt_pend_d;
    logic [1:0]       phase_bus_q, phase_bus_d;
    logic             phase_load_q, phase_load_d;
    logic             mem_req_q, mem_req_d;
    logic             fault_q, fault_d;
    logic [7:0]       count_q, count_d;

    logic             ack_now;
    logic             halt_now;
    logic             phase_change;

    function automatic logic [1:0] phase_code(input state_t s);
        case (s)
            S_DECODE:    phase_code = 2'b01;
            S_EXECUTE:   phase_code = 2'b10;
            S_WRITEBACK: phase_code = 2'b11;
            default:     phase_code = 2'b00;
        endcase
    endfunction

    function automatic logic is_instr_phase(input state_t s);
        is_instr_phase = (s == S_FETCH) || (s == S_DECODE) ||
                         (s == S_EXECUTE) || (s == S_WRITEBACK);
    endfunction

    // Halt takes priority over Run at every instruction boundary.
    function automatic state_t boundary_target(input logic halt, input logic run);
        if (halt) begin
            boundary_target = S_HALTED;
        end else if (run) begin
            boundary_target = S_FETCH;
        end else begin
            boundary_target = S_IDLE;
        end
    endfunction

    always_comb begin
        ack_now     = Mem_ack & mem_req_q;
        halt_now    = halt_pend_q | Halt;
        state_d     = state_q;
        skip_d      = skip_q;
        count_d     = count_q;
        halt_pend_d = halt_now;

        case (state_q)
            S_IDLE: begin
                if (halt_now) begin
                    state_d = S_HALTED;
                end else if (Run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // An ack in the timeout cycle itself still counts as a successful fetch.
                if ((acked_q || ack_now) && (age_q >= AGE_TWO)) begin
                    state_d = S_DECODE;
                end else if (!acked_q && !ack_now && (age_q == AGE_TMO)) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                if (age_q >= AGE_TWO) begin
                    skip_d  = Skip_wb;
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (age_q >= AGE_EXEC) begin
                    if (skip_q) begin
                        count_d = count_q + 8'd1;
                        state_d = boundary_target(halt_now, Run);
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end
            end
            S_WRITEBACK: begin
                if (age_q >= AGE_TWO) begin
                    count_d = count_q + 8'd1;
                    state_d = boundary_target(halt_now, Run);
                end
            end
            S_HALTED: state_d = S_HALTED;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_IDLE;
        endcase

        phase_change = (state_d != state_q);

        if (phase_change) begin
            age_d = AGE_ONE;
        end else if (age_q == AGE_SAT) begin
            age_d = age_q;
        end else begin
            age_d = age_q + AGE_ONE;
        end

        acked_d      = phase_change ? 1'b0 : (acked_q | ack_now);
        phase_bus_d  = phase_code(state_d);
        // Strobe lands in the 2nd cycle so the bus has already been stable for one cycle.
        phase_load_d = is_instr_phase(state_d) && !phase_change && (age_q == AGE_ONE);
        mem_req_d    = (state_d == S_FETCH) && (phase_change || (mem_req_q && !ack_now));
        fault_d      = (state_d == S_FAULT);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q      <= S_IDLE;
            age_q        <= '0;
            acked_q      <= 1'b0;
            skip_q       <= 1'b0;
            halt_pend_q  <= 1'b0;
            phase_bus_q  <= 2'b00;
            phase_load_q <= 1'b0;
            mem_req_q    <= 1'b0;
            fault_q      <= 1'b0;
            count_q      <= 8'd0;
        end else begin
            state_q      <= state_d;
            age_q        <= age_d;
            acked_q      <= acked_d;
            skip_q       <= skip_d;
            halt_pend_q  <= halt_pend_d;
            phase_bus_q  <= phase_bus_d;
            phase_load_q <= phase_load_d;
            mem_req_q    <= mem_req_d;
            fault_q      <= fault_d;
            count_q      <= count_d;
        end
    end

    assign Phase_bus   = phase_bus_q;
    assign Phase_load  = phase_load_q;
    assign Mem_req     = mem_req_q;
    assign Fault       = fault_q;
    assign Instr_count = count_q;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Bench for cpu_phase_sequencer: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the phase rules.
module tb_cpu_phase_sequencer;

    localparam int FT = 15;
    localparam int EC = 2;

    localparam int P_FETCH = 0;
    localparam int P_DEC   = 1;
    localparam int P_EXE   = 2;
    localparam int P_WB    = 3;
    localparam int P_IDLE  = 4;
    localparam int P_HALT  = 5;
    localparam int P_FAULT = 6;

    logic       Clock;
    logic       Reset;
    logic       Run;
    logic       Halt;
    logic       Mem_ack;
    logic       Skip_wb;
    logic [1:0] Phase_bus;
    logic       Phase_load;
    logic       Mem_req;
    logic       Fault;
    logic [7:0] Instr_count;

    int n_checks;
    int n_errors;

    int m_ph;
    int m_cyc;
    int m_count;
    bit m_acked;
    bit m_skip;
    bit m_hpend;

    cpu_phase_sequencer #(
        .FETCH_TIMEOUT(FT),
        .EXEC_CYCLES  (EC)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Run        (Run),
        .Halt       (Halt),
        .Mem_ack    (Mem_ack),
        .Skip_wb    (Skip_wb),
        .Phase_bus  (Phase_bus),
        .Phase_load (Phase_load),
        .Mem_req    (Mem_req),
        .Fault      (Fault),
        .Instr_count(Instr_count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph    = P_IDLE;
        m_cyc   = 1;
        m_count = 0;
        m_acked = 0;
        m_skip  = 0;
        m_hpend = 0;
    endtask

    function automatic bit in_instr();
        return (m_ph <= P_WB);
    endfunction

    task automatic check_outputs();
        check_val("bus",   Phase_bus,   in_instr() ? m_ph : 0);
        check_val("load",  Phase_load,  (in_instr() && m_cyc == 2) ? 1 : 0);
        check_val("req",   Mem_req,     (m_ph == P_FETCH && !m_acked) ? 1 : 0);
        check_val("fault", Fault,       (m_ph == P_FAULT) ? 1 : 0);
        check_val("count", Instr_count, m_count);
    endtask

    function automatic int retire(input bit hnow, input bit r);
        m_count = (m_count + 1) % 256;
        if (hnow) return P_HALT;
        if (r) return P_FETCH;
        return P_IDLE;
    endfunction

    task automatic model_edge(input bit r, input bit h, input bit a, input bit s);
        bit ack;
        bit hnow;
        int nxt;
        ack     = a && (m_ph == P_FETCH) && !m_acked;
        hnow    = m_hpend | h;
        m_hpend = hnow;
        nxt     = m_ph;
        case (m_ph)
            P_IDLE:  nxt = hnow ? P_HALT : (r ? P_FETCH : P_IDLE);
            P_FETCH: begin
                if ((m_acked || ack) && m_cyc >= 2) nxt = P_DEC;
                else if (!(m_acked || ack) && m_cyc == FT) nxt = P_FAULT;
            end
            P_DEC: if (m_cyc == 2) begin m_skip = s; nxt = P_EXE; end
            P_EXE: if (m_cyc == EC) nxt = m_skip ? retire(hnow, r) : P_WB;
            P_WB:  if (m_cyc == 2) nxt = retire(hnow, r);
            default: nxt = m_ph;
        endcase
        m_acked = m_acked | ack;
        if (nxt != m_ph) begin
            m_ph    = nxt;
            m_cyc   = 1;
            m_acked = 0;
        end else begin
            m_cyc++;
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit r, input bit h, input bit a, input bit s);
        check_outputs();
        Run     = r;
        Halt    = h;
        Mem_ack = a;
        Skip_wb = s;
        @(posedge Clock);
        model_edge(r, h, a, s);
        @(negedge Clock);
    endtask

    task automatic apply_reset();
        #2;
        Reset = 1'b0;
        #1;
        check_val("rst_bus",   Phase_bus,   0);
        check_val("rst_load",  Phase_load,  0);
        check_val("rst_req",   Mem_req,     0);
        check_val("rst_fault", Fault,       0);
        check_val("rst_count", Instr_count, 0);
        model_reset();
        Run = 0; Halt = 0; Mem_ack = 0; Skip_wb = 0;
        @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    initial begin
        int t1_bus  [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
        int t1_load [9] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
        int t4_bus  [7] = '{0, 0, 1, 1, 2, 2, 0};
        int req_cnt;
        int ld_cnt;
        int ack_pct;

        n_checks = 0;
        n_errors = 0;
        Reset = 1'b0;
        Run = 0; Halt = 0; Mem_ack = 0; Skip_wb = 0;
        model_reset();
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        check_outputs();
        Reset = 1'b1;

        // Basic instruction with immediate ack.
        for (int k = 0; k <= 9; k++) begin
            if (k >= 1) begin
                check_val("t1_bus",  Phase_bus,  t1_bus[k-1]);
                check_val("t1_load", Phase_load, t1_load[k-1]);
            end
            if (k == 9) check_val("t1_count", Instr_count, 1);
            step(1, 0, 1, 0);
        end

        // Ack arrives in FETCH cycle 6.
        apply_reset();
        step(1, 0, 0, 0);
        req_cnt = 0;
        ld_cnt  = 0;
        for (int c = 1; c <= 6; c++) begin
            if (Mem_req) req_cnt++;
            if (Phase_load) ld_cnt++;
            step(1, 0, (c == 6), 0);
        end
        check_val("t2_req_cycles", req_cnt, 6);
        check_val("t2_load_pulses", ld_cnt, 1);
        check_val("t2_decode", Phase_bus, 1);

        // Fetch timeout, then fault is sticky.
        apply_reset();
        step(1, 0, 0, 0);
        for (int c = 1; c <= FT; c++) step(1, 0, 0, 0);
        check_val("t3_fault", Fault, 1);
        check_val("t3_req", Mem_req, 0);
        check_val("t3_bus", Phase_bus, 0);
        for (int c = 0; c < 6; c++) step(1, c[0], 1, 0);
        check_val("t3_fault_hold", Fault, 1);

        // Skip writeback.
        apply_reset();
        for (int k = 0; k <= 7; k++) begin
            if (k >= 1) check_val("t4_bus", Phase_bus, t4_bus[k-1]);
            if (k == 7) check_val("t4_count", Instr_count, 1);
            step(1, 0, 1, 1);
        end

        // Halt pulse in EXECUTE: instruction completes, then halted.
        apply_reset();
        for (int k = 0; k <= 8; k++) step(1, (k == 5), 1, 0);
        check_val("t5_count", Instr_count, 1);
        ld_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (Phase_load) ld_cnt++;
            step(1, 0, 1, 0);
        end
        check_val("t5_no_load", ld_cnt, 0);
        check_val("t5_bus", Phase_bus, 0);
        check_val("t5_req", Mem_req, 0);

        // Reset mid-EXECUTE, then restart counting from zero.
        apply_reset();
        for (int k = 0; k <= 5; k++) step(1, 0, 1, 0);
        check_val("t6_in_exec", Phase_bus, 2);
        apply_reset();
        step(1, 0, 1, 0);
        check_val("t6_fetch_req", Mem_req, 1);
        check_val("t6_count", Instr_count, 0);

        // Randomized traffic.
        for (int ep = 0; ep < 30; ep++) begin
            apply_reset();
            case ($urandom_range(3, 0))
                0:       ack_pct = 3;
                1:       ack_pct = 25;
                2:       ack_pct = 60;
                default: ack_pct = 100;
            endcase
            for (int c = 0; c < 120; c++) begin
                if ($urandom_range(199, 0) == 0) apply_reset();
                step(($urandom_range(99, 0) < 85),
                     ($urandom_range(999, 0) < 6),
                     ($urandom_range(99, 0) < ack_pct),
                     $urandom_range(1, 0) == 1);
            end
        end
        check_outputs();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
